// File: rtl/img_pkg.sv
// img_pkg: shared widths, memory size, reader states and the request bounds check
package img_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int MEM_DEPTH = 262145;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    // 20-bit sum so a range ending exactly at the top byte is still legal
    function automatic logic out_of_range(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        return ({1'b0, base} + {1'b0, len}) > MEM_DEPTH[ADDR_W:0];
    endfunction
endpackage

// File: rtl/dram_stream_reader_if.sv
// dram_stream_reader_if: control, memory-port and stream signals of the reader
interface dram_stream_reader_if;
    import img_pkg::*;
    logic start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic busy;
    logic done;
    logic err;
    logic [ADDR_W-1:0] dAddr;
    logic MEM_WRITE;
    logic [DATA_W-1:0] d_out;
    logic m_valid;
    logic m_ready;
    logic [DATA_W-1:0] m_data;
    modport master (
        input  start, base_addr, length, d_out, m_ready,
        output busy, done, err, dAddr, MEM_WRITE, m_valid, m_data
    );
    modport slave (
        output start, base_addr, length, d_out, m_ready,
        input  busy, done, err, dAddr, MEM_WRITE, m_valid, m_data
    );
endinterface

// File: rtl/fifo2.sv
// fifo2: two-entry synchronous FIFO; push and pop together on a full FIFO keep it full
module fifo2
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    logic [DATA_W-1:0] r_mem [2];
    logic r_wr;
    logic r_rd;
    logic [1:0] r_cnt;
    logic w_push;
    logic w_pop;
    assign w_pop = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_full = r_cnt == 2'd2;
    assign o_empty = r_cnt == 2'd0;
    assign o_head = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr <= 1'b0;
            r_rd <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            if (w_push) r_wr <= !r_wr;
            if (w_pop) r_rd <= !r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/dram_stream_reader.sv
// dram_stream_reader: streams a bounds-checked byte range of the data memory,
// hiding the one-cycle read latency behind a two-entry output FIFO
module dram_stream_reader
    import img_pkg::*;
(
    input logic clk,
    input logic rst,
    dram_stream_reader_if.master bus
);
    state_t r_state;
    state_t w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_issued;
    logic [ADDR_W-1:0] r_emitted;
    logic [ADDR_W-1:0] r_addr;
    logic r_inflight;
    logic r_err;
    logic w_start;
    logic w_issue;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic [1:0] w_fill;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_head;
    assign w_start = r_state == IDLE && bus.start;
    assign w_pop = !w_empty && bus.m_ready;
    assign w_fill = w_full ? 2'd2 : {1'b0, !w_empty};
    assign w_addr = r_base + r_issued;
    // a pop this cycle frees a slot, so the next read may go out now and keep one byte per cycle
    assign w_issue = r_state == RUN && r_issued < r_len
                     && ({1'b0, w_fill} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    always_comb begin
        w_next = r_state;
        if (w_start && !out_of_range(bus.base_addr, bus.length))
            w_next = bus.length == '0 ? FIN : RUN;
        else if (r_state == RUN && w_pop && r_emitted + 1'b1 == r_len)
            w_next = FIN;
        else if (r_state == FIN)
            w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_base <= '0;
            r_len <= '0;
            r_issued <= '0;
            r_emitted <= '0;
            r_addr <= '0;
            r_inflight <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err <= w_start && out_of_range(bus.base_addr, bus.length);
            r_inflight <= w_issue;
            if (w_issue) r_issued <= r_issued + 1'b1;
            if (w_issue) r_addr <= w_addr;
            if (w_pop) r_emitted <= r_emitted + 1'b1;
            if (w_start) begin
                r_base <= bus.base_addr;
                r_len <= bus.length;
                r_issued <= '0;
                r_emitted <= '0;
            end
        end
    end
    fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (bus.d_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );
    assign bus.dAddr = w_issue ? w_addr : r_addr;
    assign bus.MEM_WRITE = 1'b0;
    assign bus.busy = r_state == RUN;
    assign bus.done = r_state == FIN;
    assign bus.err = r_err;
    assign bus.m_valid = !w_empty;
    assign bus.m_data = w_head;
endmodule

// File: doc/dram_stream_reader.md
# dram_stream_reader

Read-side DMA stage for the data memory. Once started, it walks a contiguous byte range of the 262145-byte data memory and presents each byte on a valid/ready stream toward the output/transmit stage. It drives the memory address and holds the memory write enable low. It absorbs the memory's one-cycle registered read latency so the stream sustains one byte per cycle while the consumer is ready.

## Interface
Parameters:
- ADDR_W, 19, memory address width
- DATA_W, 8, byte width
- MEM_DEPTH, 262145, number of addressable bytes (0..262144)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address, sampled with start
- length  in  ADDR_W  byte count, sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: transfer complete
- err  out  1  one-cycle pulse: request rejected, range out of bounds
- dAddr  out  ADDR_W  memory read address
- MEM_WRITE  out  1  memory write enable, constant 0
- d_out  in  DATA_W  memory read data; reflects the dAddr of the previous cycle
- m_valid  out  1  stream byte valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_W  stream byte

## Operation
- States: IDLE, RUN, FIN.
- **IDLE, start=1:**
  - If base_addr+length > MEM_DEPTH (19-bit operands, 20-bit compare): pulse err next cycle and stay in IDLE.
  - If length=0: go to FIN.
  - Otherwise latch base_addr and length, clear issue and emit counters, go to RUN.
- **start** is ignored when not in IDLE.
- **RUN, reads:** issue a read (dAddr = base + issued) when issued < length and fill + inflight < 2.
  - fill is the 2-entry output FIFO count; inflight is 1 if a read was issued the previous cycle.
- **RUN, capture:** the byte on d_out is pushed into the FIFO in the cycle after each issue.
- **RUN, output:** m_valid = FIFO non-empty and m_data = FIFO head. Pop on m_valid & m_ready.
- **RUN, exit:** when emitted = length after a pop, go to FIN.
- **FIN:** done=1 for one cycle, busy=0, then return to IDLE.
- **dAddr** holds its last value when not issuing and is 0 after reset. A repeated read of a held address is harmless because capture is gated by inflight.
- **Addresses** never wrap; the err check guarantees base+length-1 ≤ 262144.
- **m_data and m_valid** stay stable while m_valid=1 and m_ready=0.

## Timing
- **Reset values:** busy=0, done=0, err=0, m_valid=0, m_data=0, dAddr=0, MEM_WRITE=0, state IDLE, FIFO empty.
- **Reset mid-transfer:** abort immediately; no done pulse; any byte in flight is discarded.
- **start accepted in cycle C:**
  - busy=1 from C+1.
  - dAddr=base_addr during C+1.
  - byte captured at the end of C+2.
  - m_valid=1 from C+3.
- **Throughput:** with m_ready held high, one byte per cycle after the first; bytes come out in ascending address order.
- **Backpressure:** with m_ready=0 the FIFO fills to 2 and issue stops. At most 2 bytes are buffered or in flight.
- **Final pop in cycle P:** state FIN during P+1, done=1 and busy=0 in P+1.
- **length=0:** done in C+1, no m_valid.
- **err:** in C+1; busy stays 0.
- **Simultaneous push and pop** on a full FIFO: supported; fill is unchanged.

## Structure
- **Shared package img_pkg:** ADDR_W, DATA_W, MEM_DEPTH, and the state typedef (IDLE/RUN/FIN).
- **Sub-module fifo2:** a 2-entry synchronous FIFO with push/pop/full/empty/head.
- **Top level:** FSM, counters, issue credit logic, and the bounds check.

## Test plan
- **Basic run:** memory[100..103]=0xA0..0xA3, start base=100 len=4, m_ready=1 → m_valid from C+3, data A0,A1,A2,A3 on consecutive cycles, done at last pop +1, MEM_WRITE always 0.
- **Backpressure:** same run with m_ready toggling 1,0,0,1,… → byte order preserved, m_data stable while stalled, dAddr never more than 2 ahead of emitted.
- **Bounds:**
  - base=262144 len=1 → one byte (the top address), done.
  - base=262144 len=2 → err pulse in C+1, no m_valid, busy=0.
- **Zero length and busy:**
  - len=0 → done in C+1, no m_valid.
  - start asserted during RUN → ignored; counts unchanged.
- **Reset mid-transfer:** rst after 2 of 8 bytes → next cycle m_valid=0, busy=0, no done. A fresh start then streams a full 8 bytes correctly.
